// File: rtl/loop_ctrl_pkg.sv
// Shared sequencer state encoding and defaults for the loop-control qualification stage.
package loop_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_OFF = 2'd0,
    ST_SS  = 2'd1,
    ST_RUN = 2'd2,
    ST_HIC = 2'd3
  } lc_state_e;

  localparam int unsigned LC_CW_DEF = 16;

  // OFF and HIC are the states in which the overcurrent inhibit is held asserted.
  function automatic logic inhibit_state(input lc_state_e s);
    return (s == ST_OFF) || (s == ST_HIC);
  endfunction

endpackage

// File: rtl/loop_ctrl_debounce.sv
// Consecutive-cycle debounce counter: pulses hit on the N-th consecutive cycle of inc, then restarts.
module loop_ctrl_debounce
  import loop_ctrl_pkg::*;
#(
  parameter int unsigned N  = 2,
  parameter int unsigned CW = LC_CW_DEF
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic inc,
  output logic hit
);

  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // A synchronous clear overrides everything, including a would-be hit in the same cycle.
  always_comb begin
    hit   = 1'b0;
    cnt_d = '0;
    if (!clr && inc) begin
      if (cnt_q == LAST) begin
        hit = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/loop_ctrl_qual.sv
// Qualification stage feeding the three-input NOR of the loop control path:
// produces the overcurrent, undervoltage and soft-start/hiccup inhibits.
module loop_ctrl_qual
  import loop_ctrl_pkg::*;
#(
  parameter int unsigned BLANK_CYC = 8,
  parameter int unsigned OC_DEB    = 2,
  parameter int unsigned UV_DEB    = 16,
  parameter int unsigned SS_CYC    = 1024,
  parameter int unsigned HIC_CNT   = 4,
  parameter int unsigned HIC_OFF   = 4096,
  parameter int unsigned CW        = LC_CW_DEF
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       CELV,
  input  logic       CELG,
  input  logic       SUB,
  input  logic       en,
  input  logic       pwm,
  input  logic       oc_cmp,
  input  logic       uv_cmp,
  output logic       flt_oc,
  output logic       flt_uv,
  output logic       ss_busy,
  output logic [1:0] state
);

  localparam logic [CW-1:0] BLANK_LD = CW'(BLANK_CYC);
  localparam logic [CW-1:0] SS_LAST  = CW'(SS_CYC - 1);
  localparam logic [CW-1:0] HIC_LAST = CW'(HIC_OFF - 1);
  localparam logic [CW-1:0] PER_MAX  = CW'(HIC_CNT);

  // Power pins carry no logic; they are folded into a sink so they remain visible ports.
  logic unused_pins;
  assign unused_pins = ^{CELV, CELG, SUB};

  lc_state_e     state_q, state_d;
  logic          pwm_q, pwm_d;
  logic [CW-1:0] blank_q, blank_d;
  logic          oc_latch_q, oc_latch_d;
  logic [CW-1:0] oc_per_q, oc_per_d;
  logic [CW-1:0] ss_cnt_q, ss_cnt_d;
  logic [CW-1:0] hic_cnt_q, hic_cnt_d;
  logic          flt_oc_q, flt_oc_d;
  logic          flt_uv_q, flt_uv_d;
  logic          ss_busy_q, ss_busy_d;

  logic          pwm_rise;
  logic          oc_deb_inc;
  logic          oc_hit;
  logic          uv_mismatch;
  logic          uv_hit;

  assign pwm_rise    = pwm && !pwm_q;
  assign oc_deb_inc  = oc_cmp && (blank_q == '0);
  assign uv_mismatch = uv_cmp ^ flt_uv_q;

  loop_ctrl_debounce #(
    .N  (OC_DEB),
    .CW (CW)
  ) u_oc_deb (
    .clk  (clk),
    .rstn (rstn),
    .clr  (pwm_rise),
    .inc  (oc_deb_inc),
    .hit  (oc_hit)
  );

  loop_ctrl_debounce #(
    .N  (UV_DEB),
    .CW (CW)
  ) u_uv_deb (
    .clk  (clk),
    .rstn (rstn),
    .clr  (1'b0),
    .inc  (uv_mismatch),
    .hit  (uv_hit)
  );

  // Leading-edge blanking: the comparator is ignored while the counter is nonzero.
  always_comb begin
    pwm_d   = pwm;
    blank_d = blank_q;
    if (pwm_rise) begin
      blank_d = BLANK_LD;
    end else if (blank_q != '0) begin
      blank_d = blank_q - CW'(1);
    end
  end

  // The latch remembers an OC event for the whole PWM period; the edge always wins.
  always_comb begin
    oc_latch_d = oc_latch_q;
    if (pwm_rise) begin
      oc_latch_d = 1'b0;
    end else if (oc_hit) begin
      oc_latch_d = 1'b1;
    end

    oc_per_d = oc_per_q;
    if (pwm_rise) begin
      if (!oc_latch_q) begin
        oc_per_d = '0;
      end else if (oc_per_q != PER_MAX) begin
        oc_per_d = oc_per_q + CW'(1);
      end
    end
    if (inhibit_state(state_d)) begin
      oc_per_d = '0;
    end
  end

  always_comb begin
    flt_uv_d = flt_uv_q ^ uv_hit;
  end

  // Sequencer; loss of enable or an undervoltage flag overrides every other transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_OFF: begin
        if (en && !flt_uv_q) begin
          state_d = ST_SS;
        end
      end
      ST_SS: begin
        if (oc_per_q == PER_MAX) begin
          state_d = ST_HIC;
        end else if (ss_cnt_q == SS_LAST) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (oc_per_q == PER_MAX) begin
          state_d = ST_HIC;
        end
      end
      ST_HIC: begin
        if (hic_cnt_q == HIC_LAST) begin
          state_d = ST_SS;
        end
      end
      default: state_d = ST_OFF;
    endcase
    if (!en || flt_uv_q) begin
      state_d = ST_OFF;
    end
  end

  // Timers restart from zero on every entry and only advance while the state is kept.
  always_comb begin
    ss_cnt_d  = '0;
    hic_cnt_d = '0;
    if ((state_q == ST_SS) && (state_d == ST_SS)) begin
      ss_cnt_d = ss_cnt_q + CW'(1);
    end
    if ((state_q == ST_HIC) && (state_d == ST_HIC)) begin
      hic_cnt_d = hic_cnt_q + CW'(1);
    end
  end

  // Outputs follow the next state so they change together with the state register.
  always_comb begin
    flt_oc_d  = inhibit_state(state_d) || oc_latch_d;
    ss_busy_d = (state_d != ST_RUN);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_OFF;
      pwm_q      <= 1'b0;
      blank_q    <= '0;
      oc_latch_q <= 1'b0;
      oc_per_q   <= '0;
      ss_cnt_q   <= '0;
      hic_cnt_q  <= '0;
      flt_oc_q   <= 1'b1;
      flt_uv_q   <= 1'b1;
      ss_busy_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      pwm_q      <= pwm_d;
      blank_q    <= blank_d;
      oc_latch_q <= oc_latch_d;
      oc_per_q   <= oc_per_d;
      ss_cnt_q   <= ss_cnt_d;
      hic_cnt_q  <= hic_cnt_d;
      flt_oc_q   <= flt_oc_d;
      flt_uv_q   <= flt_uv_d;
      ss_busy_q  <= ss_busy_d;
    end
  end

  assign flt_oc  = flt_oc_q;
  assign flt_uv  = flt_uv_q;
  assign ss_busy = ss_busy_q;
  assign state   = state_q;

endmodule

// File: tb/tb_loop_ctrl_qual.sv
// Directed self-checking bench for loop_ctrl_qual with default parameters.
module tb_loop_ctrl_qual;

  logic       clk;
  logic       rstn;
  logic       celv;
  logic       celg;
  logic       sub;
  logic       en;
  logic       pwm;
  logic       oc_cmp;
  logic       uv_cmp;
  logic       flt_oc;
  logic       flt_uv;
  logic       ss_busy;
  logic [1:0] state;

  int n_checks;
  int n_fail;

  loop_ctrl_qual dut (
    .clk     (clk),
    .rstn    (rstn),
    .CELV    (celv),
    .CELG    (celg),
    .SUB     (sub),
    .en      (en),
    .pwm     (pwm),
    .oc_cmp  (oc_cmp),
    .uv_cmp  (uv_cmp),
    .flt_oc  (flt_oc),
    .flt_uv  (flt_uv),
    .ss_busy (ss_busy),
    .state   (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic en_i, input logic pwm_i, input logic oc_i, input logic uv_i);
    en     = en_i;
    pwm    = pwm_i;
    oc_cmp = oc_i;
    uv_cmp = uv_i;
  endtask

  // Advance n rising edges; every call starts and ends on a falling edge.
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [1:0] st_w, input logic oc_w,
                             input logic uv_w, input logic busy_w);
    logic [4:0] obs;
    logic [4:0] want;
    obs  = {state, flt_oc, flt_uv, ss_busy};
    want = {st_w, oc_w, uv_w, busy_w};
    n_checks++;
    assert (obs === want) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed state=%0d oc=%b uv=%b busy=%b, expected state=%0d oc=%b uv=%b busy=%b",
             tag, obs[4:3], obs[2], obs[1], obs[0], want[4:3], want[2], want[1], want[0]);
    end
  endtask

  // One PWM period with the comparator high long enough to pass blanking and debounce.
  task automatic ocPeriod();
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    cyc(12);
  endtask

  task automatic quietEdge();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached before the end of the sequence");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    celv = 1'b1;
    celg = 1'b0;
    sub  = 1'b0;
    rstn = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(3);
    checkOutput("reset", 2'd0, 1'b1, 1'b1, 1'b1);

    // Power-up: undervoltage clears after 16 cycles, then soft-start for 1024 cycles.
    rstn = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(15);
    checkOutput("uv_deb_15", 2'd0, 1'b1, 1'b1, 1'b1);
    cyc(1);
    checkOutput("uv_clear_16", 2'd0, 1'b1, 1'b0, 1'b1);
    cyc(1);
    checkOutput("ss_entry", 2'd1, 1'b0, 1'b0, 1'b1);
    cyc(1023);
    checkOutput("ss_last", 2'd1, 1'b0, 1'b0, 1'b1);
    cyc(1);
    checkOutput("run_entry", 2'd2, 1'b0, 1'b0, 1'b0);

    // OC latency: flag exactly 10 cycles after the rising-edge cycle.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1);
    checkOutput("oc_edge", 2'd2, 1'b0, 1'b0, 1'b0);
    cyc(9);
    checkOutput("oc_edge_p9", 2'd2, 1'b0, 1'b0, 1'b0);
    cyc(1);
    checkOutput("oc_edge_p10", 2'd2, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1);
    checkOutput("oc_hold", 2'd2, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1);
    checkOutput("oc_clear", 2'd2, 1'b0, 1'b0, 1'b0);

    // A 7-cycle comparator pulse lies entirely inside blanking.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    cyc(7);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(6);
    checkOutput("blank_pulse", 2'd2, 1'b0, 1'b0, 1'b0);

    // Rising edge coincides with the debounce completing: the edge wins.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    cyc(9);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1);
    checkOutput("edge_wins", 2'd2, 1'b0, 1'b0, 1'b0);

    // Four OC periods in RUN, closed by a fifth edge, trigger hiccup one cycle later.
    repeat (4) ocPeriod();
    checkOutput("four_oc", 2'd2, 1'b1, 1'b0, 1'b0);
    quietEdge();
    checkOutput("fifth_edge", 2'd2, 1'b0, 1'b0, 1'b0);
    cyc(1);
    checkOutput("hic_entry", 2'd3, 1'b1, 1'b0, 1'b1);
    cyc(4095);
    checkOutput("hic_last", 2'd3, 1'b1, 1'b0, 1'b1);
    cyc(1);
    checkOutput("hic_exit", 2'd1, 1'b0, 1'b0, 1'b1);
    cyc(1024);
    checkOutput("run_again", 2'd2, 1'b0, 1'b0, 1'b0);

    // Undervoltage: 15 cycles is filtered out, 16 cycles sets the flag.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    cyc(15);
    checkOutput("uv_pulse_15", 2'd2, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(2);
    checkOutput("uv_pulse_after", 2'd2, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    cyc(15);
    checkOutput("uv_hold_15", 2'd2, 1'b0, 1'b0, 1'b0);
    cyc(1);
    checkOutput("uv_set_16", 2'd2, 1'b0, 1'b1, 1'b0);
    cyc(1);
    checkOutput("uv_off", 2'd0, 1'b1, 1'b1, 1'b1);

    // Recover, then reach hiccup from soft-start.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(16);
    checkOutput("uv_recover", 2'd0, 1'b1, 1'b0, 1'b1);
    cyc(1);
    checkOutput("ss_reentry", 2'd1, 1'b0, 1'b0, 1'b1);
    repeat (4) ocPeriod();
    quietEdge();
    checkOutput("ss_fifth_edge", 2'd1, 1'b0, 1'b0, 1'b1);
    cyc(1);
    checkOutput("ss_to_hic", 2'd3, 1'b1, 1'b0, 1'b1);
    cyc(100);
    checkOutput("hic_mid", 2'd3, 1'b1, 1'b0, 1'b1);

    // Asynchronous reset between clock edges, in the middle of hiccup.
    #2;
    rstn = 1'b0;
    #1;
    checkOutput("async_reset", 2'd0, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    rstn = 1'b1;
    cyc(16);
    checkOutput("rst_uv_clear", 2'd0, 1'b1, 1'b0, 1'b1);
    cyc(1);
    checkOutput("rst_ss_entry", 2'd1, 1'b0, 1'b0, 1'b1);

    // Enable dropping during hiccup abandons the hiccup timer.
    repeat (4) ocPeriod();
    quietEdge();
    cyc(1);
    checkOutput("hic_again", 2'd3, 1'b1, 1'b0, 1'b1);
    cyc(10);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1);
    checkOutput("en_drop_off", 2'd0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1);
    checkOutput("en_restart_ss", 2'd1, 1'b0, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
